// File: rtl/bcd_bin.sv
// bcd_bin: two-digit BCD (+ optional quarter fraction) to binary quarter-units.
// Reverse double-dabble over 7 shift edges; fixed 8-cycle start-to-done latency.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - conversion request, sampled only in IDLE
//   bcd    - [15:12] tens, [11:8] ones, [7:0] fraction code 00/25/50/75
//   busy   - conversion in progress
//   done   - one-cycle pulse when bin/err update
//   bin    - integer*4 + fraction index
//   err    - invalid input flag, held until next done
// Parameter LAT_CHK: 1 = validate input, 0 = err forced low.
// Macro BCD_BIN_FRAC_EN: enables fraction decoding and fraction checking.

module bcd_bin #(
    parameter int LAT_CHK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bin,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [14:0] r_sr;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic        r_done;
    logic [7:0]  r_bin;
    logic        r_err;

    logic [14:0] w_sh;
    logic [3:0]  w_t;
    logic [3:0]  w_o;
    logic [14:0] w_sr_nxt;
    logic [1:0]  w_fidx;
    logic        w_fbad;
    logic        w_bad;
    logic        w_err;

    // Shift right, then pull each digit back by 3 if it reached 8.
    assign w_sh     = {1'b0, r_sr[14:1]};
    assign w_t      = w_sh[14:11];
    assign w_o      = w_sh[10:7];
    assign w_sr_nxt = {(w_t >= 4'd8) ? w_t - 4'd3 : w_t,
                       (w_o >= 4'd8) ? w_o - 4'd3 : w_o,
                       w_sh[6:0]};

`ifdef BCD_BIN_FRAC_EN
    logic [7:0] r_frac;

    always_comb begin
        w_fidx = 2'b00;
        w_fbad = 1'b0;
        case (r_frac)
            8'h00:   w_fidx = 2'd0;
            8'h25:   w_fidx = 2'd1;
            8'h50:   w_fidx = 2'd2;
            8'h75:   w_fidx = 2'd3;
            default: w_fbad = 1'b1;
        endcase
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^bcd[7:0];
    assign w_fidx        = 2'b00;
    assign w_fbad        = 1'b0;
`endif

    // r_sr[6] set means the integer part exceeds 63.
    assign w_bad = (r_tens > 4'd9) | (r_ones > 4'd9) | r_sr[6] | w_fbad;
    assign w_err = (LAT_CHK != 0) && w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == 3'd6) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_sr   <= 15'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_done <= 1'b0;
            r_bin  <= 8'h00;
            r_err  <= 1'b0;
`ifdef BCD_BIN_FRAC_EN
            r_frac <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt  <= 3'd0;
                        r_sr   <= {bcd[15:8], 7'd0};
                        r_tens <= bcd[15:12];
                        r_ones <= bcd[11:8];
`ifdef BCD_BIN_FRAC_EN
                        r_frac <= bcd[7:0];
`endif
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_nxt;
                    r_cnt <= r_cnt + 3'd1;
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_err  <= w_err;
                    r_bin  <= w_err ? 8'h00 : {r_sr[5:0], w_fidx};
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign bin  = r_bin;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_bin.sv
// tb_bcd_bin: table-driven vectors with a done-driven scoreboard,
// plus hand sequences for ignored starts, reset abort and back-to-back.

module tb_bcd_bin;

`ifdef BCD_BIN_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd   = 16'h0000;
    logic        busy;
    logic        done;
    logic [7:0]  bin;
    logic        err;

    bcd_bin #(.LAT_CHK(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    typedef struct {
        logic [7:0] bin;
        logic       err;
        int         due;
    } exp_t;

    typedef struct {
        logic [15:0] bcd;
        logic [7:0]  bf;
        logic        ef;
        logic [7:0]  bn;
        logic        en;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vt[12];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [7:0]  last_bin = 8'h00;
    logic        last_err = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none",
                         cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("bin", {24'd0, bin}, {24'd0, mon_e.bin});
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [15:0] v, input logic [7:0] eb,
                          input logic ee);
        exp_t e;
        start = 1'b1;
        bcd   = v;
        e.bin = eb;
        e.err = ee;
        e.due = cyc + 9;
        sbq.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected %0d pending",
                     sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        vt[0]  = '{16'h2575, 8'h67, 1'b0, 8'h64, 1'b0};
        vt[1]  = '{16'h6375, 8'hFF, 1'b0, 8'hFC, 1'b0};
        vt[2]  = '{16'h6400, 8'h00, 1'b1, 8'h00, 1'b1};
        vt[3]  = '{16'h1A00, 8'h00, 1'b1, 8'h00, 1'b1};
        vt[4]  = '{16'h1230, 8'h00, 1'b1, 8'h30, 1'b0};
        vt[5]  = '{16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{16'h9900, 8'h00, 1'b1, 8'h00, 1'b1};
        vt[7]  = '{16'h0950, 8'h26, 1'b0, 8'h24, 1'b0};
        vt[8]  = '{16'h1099, 8'h00, 1'b1, 8'h28, 1'b0};
        vt[9]  = '{16'hA000, 8'h00, 1'b1, 8'h00, 1'b1};
        vt[10] = '{16'h3325, 8'h85, 1'b0, 8'h84, 1'b0};
        vt[11] = '{16'h0525, 8'h15, 1'b0, 8'h14, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bin", {24'd0, bin}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // First start presented together with reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (FRAC) launch(vt[i].bcd, vt[i].bf, vt[i].ef);
            else      launch(vt[i].bcd, vt[i].bn, vt[i].en);
            @(negedge clk);
            start = 1'b0;
            bcd   = ~bcd;
            chk("busy", {31'd0, busy}, 32'd1);
            repeat (3) @(negedge clk);
            chk("hold_bin", {24'd0, bin}, {24'd0, last_bin});
            chk("hold_err", {31'd0, err}, {31'd0, last_err});
            drain();
            last_bin = FRAC ? vt[i].bf : vt[i].bn;
            last_err = FRAC ? vt[i].ef : vt[i].en;
        end

        // Start while busy is ignored; operand stays as captured.
        @(negedge clk);
        launch(16'h0100, 8'h04, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h9900;
        @(negedge clk);
        start = 1'b0;
        bcd   = 16'hFFFF;
        drain();
        repeat (12) @(negedge clk);

        // Reset mid-conversion aborts; no done afterwards.
        launch(16'h4250, FRAC ? 8'hAA : 8'hA8, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bin", {24'd0, bin}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        launch(16'h4250, FRAC ? 8'hAA : 8'hA8, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start in FINISH ignored; start in the done cycle accepted.
        @(negedge clk);
        launch(16'h2575, FRAC ? 8'h67 : 8'h64, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b1;
        bcd   = 16'h9900;
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        launch(16'h0950, FRAC ? 8'h26 : 8'h24, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        drain();
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_bin.md
BCD_BIN -- requirements
Module: bcd_bin

Interface
REQ-001 The module SHALL have one parameter: LAT_CHK, default 1, meaning range/digit validation is performed (1) or `err` is forced to 0 (0).
REQ-002 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port start, input, 1, request to convert `bcd`; sampled only in IDLE.
REQ-005 Port bcd, input, 16, [15:12] tens digit, [11:8] ones digit, [7:0] fraction code 8'h00/25/50/75 (.00/.25/.50/.75).
REQ-006 Port busy, output, 1, high while a conversion is in progress.
REQ-007 Port done, output, 1, one-cycle pulse when `bin` and `err` are updated.
REQ-008 Port bin, output, 8, unsigned value in quarter-units: integer*4 + fraction index.
REQ-009 Port err, output, 1, invalid input flag for the last conversion, valid with `done` and held until the next `done`.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, and FINISH.
REQ-011 In IDLE with start=1 at edge E0, `bcd` SHALL be captured, busy SHALL go high, the 3-bit shift counter SHALL clear, and the FSM SHALL enter SHIFT.
REQ-012 In SHIFT, each edge SHALL shift the 15-bit register {tens, ones, int[6:0]} right by one, then subtract 3 from each digit ≥ 8.
REQ-013 SHIFT SHALL last exactly 7 edges (E1..E7); int[6:0] SHALL then equal tens*10+ones.
REQ-014 At E8 (FINISH), the FSM SHALL do the following: load bin = {int[5:0], frac_idx}; assert done for exactly one cycle; deassert busy; return to IDLE.
REQ-015 Latency from the start-sampling edge to done high SHALL be 8 cycles, fixed regardless of data or error.
REQ-016 Bits frac_idx SHALL be 8'h00→0, 8'h25→1, 8'h50→2, 8'h75→3.
REQ-017 Signal err SHALL be 1 if any of the following holds: tens>9, ones>9, integer>63, or the fraction code is not one of the four legal codes.
REQ-018 When err=1, bin SHALL be loaded with 8'h00.
REQ-019 Input start while busy=1 SHALL be ignored, with no queueing, and the captured operand SHALL be unchanged.
REQ-020 Input start asserted in the FINISH cycle SHALL be ignored; a new conversion SHALL be accepted on the first IDLE cycle after done.
REQ-021 Outputs bin and err SHALL hold their last values while IDLE and SHIFT, changing only at the done edge.
REQ-022 Input bcd changing after E0 SHALL NOT affect the result.

Reset
REQ-023 While rst_n=0, the module SHALL asynchronously force FSM=IDLE, counter=0, busy=0, done=0, bin=8'h00, and err=0.
REQ-024 Reset asserted mid-conversion SHALL abort it, and no done SHALL follow reset release.
REQ-025 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro BCD_BIN_FRAC_EN defined: fraction decoding SHALL be included per REQ-016, and illegal fraction codes SHALL set err.
REQ-027 Macro BCD_BIN_FRAC_EN undefined: bcd[7:0] SHALL be ignored, bin[1:0] SHALL be 2'b00, and the fraction SHALL never set err.
REQ-028 Latency and handshake SHALL be identical in both builds.

Verification
REQ-029 With FRAC_EN, start with bcd=16'h2575 -> done 8 cycles later, bin=8'h67, err=0.
REQ-030 With FRAC_EN: bcd=16'h6375 -> bin=8'hFF, err=0; bcd=16'h6400 -> bin=8'h00, err=1.
REQ-031 bcd=16'h1A00 (ones=10) -> err=1, bin=8'h00; bcd=16'h1230 -> err=1 with FRAC_EN, and err=0 with bin=8'h30 without it.
REQ-032 Start with bcd=16'h0100, then start with bcd=16'h9900 at cycle 3 -> single done at cycle 8, bin=8'h04, err=0.
REQ-033 Start with bcd=16'h4250, then rst_n low at cycle 4 -> busy=0, bin=8'h00 immediately, no done; a new start with 16'h4250 -> bin=8'hAA.
REQ-034 Back-to-back: start at cycle 9 (first IDLE after done) SHALL be accepted -> second done at cycle 17.
